// File: rtl/car_ampl_pkg.sv
// Shared constants and state encoding for the carrier amplitude measurement block.
package car_ampl_pkg;

  localparam int unsigned DW_DEF = 12;

  localparam logic [DW_DEF-1:0] SMP_MIN = '0;
  localparam logic [DW_DEF-1:0] SMP_MAX = '1;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_ACC   = 1'b1
  } meas_state_e;

endpackage

// File: rtl/car_minmax_trk.sv
// Running min/max/clip tracker. The nxt_* outputs show the values that include
// the current sample, so the caller can capture a result on the same edge.
module car_minmax_trk
  import car_ampl_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          upd_i,
  input  logic          clr_i,
  input  logic [DW-1:0] smp_i,
  output logic [DW-1:0] min_o,
  output logic [DW-1:0] max_o,
  output logic          clip_o,
  output logic [DW-1:0] nxt_min_o,
  output logic [DW-1:0] nxt_max_o,
  output logic          nxt_clip_o
);

  logic [DW-1:0] min_q, max_q;
  logic          clip_q;
  logic          at_rail;

  // Rails are derived from DW so a non-default width still flags correctly.
  assign at_rail = (smp_i == {DW{1'b0}}) || (smp_i == {DW{1'b1}});

  always_comb begin
    nxt_min_o  = min_q;
    nxt_max_o  = max_q;
    nxt_clip_o = clip_q;
    if (load_i) begin
      nxt_min_o  = smp_i;
      nxt_max_o  = smp_i;
      nxt_clip_o = at_rail;
    end else begin
      if (smp_i < min_q) nxt_min_o = smp_i;
      if (smp_i > max_q) nxt_max_o = smp_i;
      nxt_clip_o = clip_q | at_rail;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      min_q  <= '0;
      max_q  <= '0;
      clip_q <= 1'b0;
    end else if (clr_i) begin
      clip_q <= 1'b0;
    end else if (load_i || upd_i) begin
      min_q  <= nxt_min_o;
      max_q  <= nxt_max_o;
      clip_q <= nxt_clip_o;
    end
  end

  assign min_o  = min_q;
  assign max_o  = max_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/car_ampl_meas.sv
// Carrier amplitude measurement: windowed min/max over accepted samples,
// publishing peak-to-peak, midpoint and clip with a one-cycle valid strobe.
module car_ampl_meas
  import car_ampl_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned WIN_LOG2 = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          smp_en_i,
  input  logic [DW-1:0] smp_i,
  input  logic          clr_i,
  output logic [DW-1:0] ampl_pp_o,
  output logic [DW-1:0] ampl_mid_o,
  output logic          ampl_ovr_o,
  output logic          ampl_vld_o
);

  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  meas_state_e         state_q, state_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                trk_load, trk_upd, win_close;
  logic [DW-1:0]       trk_min, trk_max, nxt_min, nxt_max;
  logic                trk_clip, nxt_clip;
  logic [DW:0]         mid_sum;
  logic [DW-1:0]       pp_q, mid_q;
  logic                ovr_q, vld_q;

  car_minmax_trk #(.DW(DW)) u_trk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (trk_load),
    .upd_i      (trk_upd),
    .clr_i      (clr_i),
    .smp_i      (smp_i),
    .min_o      (trk_min),
    .max_o      (trk_max),
    .clip_o     (trk_clip),
    .nxt_min_o  (nxt_min),
    .nxt_max_o  (nxt_max),
    .nxt_clip_o (nxt_clip)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trk_load  = 1'b0;
    trk_upd   = 1'b0;
    win_close = 1'b0;
    if (clr_i) begin
      cnt_d   = '0;
      state_d = S_FIRST;
    end else if (smp_en_i) begin
      unique case (state_q)
        S_FIRST: begin
          trk_load = 1'b1;
          cnt_d    = WIN_LOG2'(1);
          state_d  = S_ACC;
        end
        S_ACC: begin
          trk_upd = 1'b1;
          if (cnt_q == CNT_LAST) begin
            win_close = 1'b1;
            cnt_d     = '0;
            state_d   = S_FIRST;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_FIRST;
      endcase
    end
  end

  assign mid_sum = {1'b0, nxt_max} + {1'b0, nxt_min};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FIRST;
      cnt_q   <= '0;
      pp_q    <= '0;
      mid_q   <= '0;
      ovr_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= win_close;
      if (win_close) begin
        pp_q  <= nxt_max - nxt_min;
        mid_q <= mid_sum[DW:1];
        ovr_q <= nxt_clip;
      end
    end
  end

  assign ampl_pp_o  = pp_q;
  assign ampl_mid_o = mid_q;
  assign ampl_ovr_o = ovr_q;
  assign ampl_vld_o = vld_q;

endmodule

// File: tb/tb_car_ampl_meas.sv
// Directed bench for car_ampl_meas with a 4-sample window.
module tb_car_ampl_meas;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        smp_en_i = 1'b0;
  logic [11:0] smp_i = '0;
  logic        clr_i = 1'b0;
  logic [11:0] ampl_pp_o, ampl_mid_o;
  logic        ampl_ovr_o, ampl_vld_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int pulses[$];

  car_ampl_meas #(.DW(12), .WIN_LOG2(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .smp_en_i   (smp_en_i),
    .smp_i      (smp_i),
    .clr_i      (clr_i),
    .ampl_pp_o  (ampl_pp_o),
    .ampl_mid_o (ampl_mid_o),
    .ampl_ovr_o (ampl_ovr_o),
    .ampl_vld_o (ampl_vld_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (ampl_vld_o === 1'b1) begin
      vld_cnt = vld_cnt + 1;
      pulses.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic en, input logic [11:0] s, input logic c);
    @(negedge clk_i);
    smp_en_i = en;
    smp_i    = s;
    clr_i    = c;
  endtask

  // Called right after the push of the window's last sample.
  task automatic check_window(input string tag, input int pp, input int mid, input int ovr);
    @(negedge clk_i);
    smp_en_i = 1'b0;
    clr_i    = 1'b0;
    chk({tag, "_vld"}, 32'(ampl_vld_o), 32'd1);
    chk({tag, "_pp"},  32'(ampl_pp_o),  32'(pp));
    chk({tag, "_mid"}, 32'(ampl_mid_o), 32'(mid));
    chk({tag, "_ovr"}, 32'(ampl_ovr_o), 32'(ovr));
    @(negedge clk_i);
    chk({tag, "_vld_off"}, 32'(ampl_vld_o), 32'd0);
  endtask

  initial begin
    int base;
    logic [11:0] s4 [4];
    logic gap [11];

    repeat (2) @(negedge clk_i);
    chk("rst_pp",  32'(ampl_pp_o),  32'd0);
    chk("rst_mid", 32'(ampl_mid_o), 32'd0);
    chk("rst_ovr", 32'(ampl_ovr_o), 32'd0);
    chk("rst_vld", 32'(ampl_vld_o), 32'd0);
    rst_i = 1'b0;

    // 1: flat 2048
    base = vld_cnt;
    for (int i = 0; i < 4; i++) push(1'b1, 12'd2048, 1'b0);
    chk("s1_nopulse_early", 32'(vld_cnt - base), 32'd0);
    check_window("s1", 0, 2048, 0);
    chk("s1_one_pulse", 32'(vld_cnt - base), 32'd1);

    // 2: mixed values
    s4[0] = 12'd1000; s4[1] = 12'd3000; s4[2] = 12'd2000; s4[3] = 12'd1500;
    for (int i = 0; i < 4; i++) push(1'b1, s4[i], 1'b0);
    check_window("s2", 2000, 2000, 0);

    // 3: rails, then small window
    push(1'b1, 12'd0, 1'b0);
    push(1'b1, 12'd4095, 1'b0);
    push(1'b1, 12'd2000, 1'b0);
    push(1'b1, 12'd2000, 1'b0);
    check_window("s3a", 4095, 2047, 1);
    for (int i = 0; i < 4; i++) push(1'b1, 12'(100 + i), 1'b0);
    check_window("s3b", 3, 101, 0);

    // 4: gapped stream of the s2 samples over 11 cycles
    gap = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    base = vld_cnt;
    begin
      int k;
      k = 0;
      for (int i = 0; i < 11; i++) begin
        if (gap[i]) begin
          push(1'b1, s4[k], 1'b0);
          k++;
        end else begin
          push(1'b0, 12'd4095, 1'b0);
        end
      end
    end
    chk("s4_nopulse_early", 32'(vld_cnt - base), 32'd0);
    check_window("s4", 2000, 2000, 0);

    // 4b: 12 back-to-back samples -> 3 pulses, 4 cycles apart
    pulses.delete();
    for (int i = 0; i < 12; i++) push(1'b1, 12'(100 + 10 * i), 1'b0);
    check_window("s4b", 30, 195, 0);
    chk("s4b_npulses", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("s4b_gap01", 32'(pulses[1] - pulses[0]), 32'd4);
      chk("s4b_gap12", 32'(pulses[2] - pulses[1]), 32'd4);
    end

    // 5: clr together with smp_en drops the sample and restarts the window
    base = vld_cnt;
    push(1'b1, 12'd4000, 1'b0);
    push(1'b1, 12'd10, 1'b0);
    push(1'b1, 12'd999, 1'b1);
    push(1'b1, 12'd500, 1'b0);
    push(1'b1, 12'd600, 1'b0);
    push(1'b1, 12'd700, 1'b0);
    chk("s5_nopulse_early", 32'(vld_cnt - base), 32'd0);
    push(1'b1, 12'd800, 1'b0);
    check_window("s5", 300, 650, 0);
    chk("s5_one_pulse", 32'(vld_cnt - base), 32'd1);

    // 5b: clr on the window-closing sample suppresses the result
    base = vld_cnt;
    for (int i = 0; i < 3; i++) push(1'b1, 12'd50, 1'b0);
    push(1'b1, 12'd60, 1'b1);
    push(1'b0, 12'd0, 1'b0);
    @(negedge clk_i);
    chk("s5b_no_pulse", 32'(vld_cnt - base), 32'd0);
    chk("s5b_pp_hold", 32'(ampl_pp_o), 32'd300);

    // 6: async reset mid-window
    push(1'b1, 12'd4095, 1'b0);
    push(1'b1, 12'd4095, 1'b0);
    @(negedge clk_i);
    smp_en_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("s6_rst_pp",  32'(ampl_pp_o),  32'd0);
    chk("s6_rst_mid", 32'(ampl_mid_o), 32'd0);
    chk("s6_rst_ovr", 32'(ampl_ovr_o), 32'd0);
    chk("s6_rst_vld", 32'(ampl_vld_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    base = vld_cnt;
    for (int i = 0; i < 3; i++) push(1'b1, 12'd1234, 1'b0);
    chk("s6_nopulse_early", 32'(vld_cnt - base), 32'd0);
    push(1'b1, 12'd1234, 1'b0);
    check_window("s6", 0, 1234, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
